// File: rtl/columns_circuit.sv
// Columns game board: a 4x4 gravity-fill board driven by the game controller state.
// One move is taken per entry into a player state; row 0 is the bottom row.
module columns_circuit (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  in_column,
    input  logic [1:0]  state,
    output logic [1:0]  column_decode,
    output logic [15:0] out_gameboard,
    output logic [15:0] out_players_cells,
    output logic        invalid_column,
    output logic        next_player
);
    localparam logic [1:0] StP1 = 2'b01;
    localparam logic [1:0] StP2 = 2'b10;

    logic [1:0]  prevState_q, prevState_d;
    logic [15:0] gameBoard_q, gameBoard_d;
    logic [15:0] playerCells_q, playerCells_d;
    logic        invalidColumn_q, invalidColumn_d;
    logic        nextPlayer_q, nextPlayer_d;

    logic        colOneHot;
    logic        moveAttempt;
    logic [15:0] colShift;
    logic [3:0]  colCells;
    logic [1:0]  freeRow;
    logic [3:0]  cellIdx;

    always_comb begin
        column_decode = 2'd0;
        colOneHot     = 1'b1;
        case (in_column)
            4'b0001: column_decode = 2'd0;
            4'b0010: column_decode = 2'd1;
            4'b0100: column_decode = 2'd2;
            4'b1000: column_decode = 2'd3;
            default: colOneHot = 1'b0;
        endcase
    end

    // Cells of the selected column, bottom row in bit 0; the column fills from the bottom
    // up, so the lowest clear bit is the landing row.
    always_comb begin
        colShift = gameBoard_q >> column_decode;
        colCells = {colShift[12], colShift[8], colShift[4], colShift[0]};
        freeRow  = 2'd0;
        for (int r = 3; r >= 0; r--) begin
            if (!colCells[r]) freeRow = r[1:0];
        end
        cellIdx = {freeRow, column_decode};
    end

    assign moveAttempt = ((state == StP1) || (state == StP2)) && (state != prevState_q);

    always_comb begin
        prevState_d     = state;
        gameBoard_d     = gameBoard_q;
        playerCells_d   = playerCells_q;
        invalidColumn_d = invalidColumn_q;
        nextPlayer_d    = nextPlayer_q;
        if (moveAttempt) begin
            if (colOneHot && !(&colCells)) begin
                gameBoard_d[cellIdx]   = 1'b1;
                playerCells_d[cellIdx] = (state == StP2);
                nextPlayer_d           = (state == StP1);
                invalidColumn_d        = 1'b0;
            end else begin
                invalidColumn_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prevState_q     <= 2'b00;
            gameBoard_q     <= 16'h0000;
            playerCells_q   <= 16'h0000;
            invalidColumn_q <= 1'b0;
            nextPlayer_q    <= 1'b0;
        end else begin
            prevState_q     <= prevState_d;
            gameBoard_q     <= gameBoard_d;
            playerCells_q   <= playerCells_d;
            invalidColumn_q <= invalidColumn_d;
            nextPlayer_q    <= nextPlayer_d;
        end
    end

    assign out_gameboard     = gameBoard_q;
    assign out_players_cells = playerCells_q;
    assign invalid_column    = invalidColumn_q;
    assign next_player       = nextPlayer_q;
endmodule

// File: tb/tb_columns_circuit.sv
// Scoreboard bench for columns_circuit: directed move vectors push hand-computed
// expectations; a negedge monitor pops and compares them on their target cycle.
module tb_columns_circuit;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  in_column;
    logic [1:0]  state;
    logic [1:0]  column_decode;
    logic [15:0] out_gameboard;
    logic [15:0] out_players_cells;
    logic        invalid_column;
    logic        next_player;

    int testsRun  = 0;
    int failCount = 0;
    int cycleCount = 0;

    typedef struct {
        int          cycle;
        int          tag;
        logic [15:0] board;
        logic [15:0] owner;
        logic        nxt;
        logic        inv;
        logic [1:0]  dec;
    } expect_t;

    typedef struct {
        bit          isReset;
        logic [1:0]  st;
        logic [3:0]  col;
        logic [3:0]  colAfter;
        int          hold;
        logic [15:0] board;
        logic [15:0] owner;
        logic        nxt;
        logic        inv;
    } vec_t;

    expect_t sb[$];
    vec_t    vecs[$];

    columns_circuit dut (
        .clk               (clk),
        .reset             (reset),
        .in_column         (in_column),
        .state             (state),
        .column_decode     (column_decode),
        .out_gameboard     (out_gameboard),
        .out_players_cells (out_players_cells),
        .invalid_column    (invalid_column),
        .next_player       (next_player)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    function automatic logic [1:0] decodeModel(input logic [3:0] col);
        case (col)
            4'b0010: return 2'd1;
            4'b0100: return 2'd2;
            4'b1000: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    task automatic checkOutput(input string name, input int tag, input logic [15:0] actual,
                               input logic [15:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s (vector %0d): got 0x%0h, expected 0x%0h", name, tag, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cycle < cycleCount) begin
            testsRun++;
            failCount++;
            $display("[TB] FAIL stale_expectation (vector %0d): got cycle %0d, expected cycle %0d",
                     sb[0].tag, cycleCount, sb[0].cycle);
            void'(sb.pop_front());
        end
        if (sb.size() > 0 && sb[0].cycle == cycleCount) begin
            expect_t e;
            e = sb.pop_front();
            checkOutput("out_gameboard", e.tag, out_gameboard, e.board);
            checkOutput("out_players_cells", e.tag, out_players_cells, e.owner);
            checkOutput("next_player", e.tag, {15'd0, next_player}, {15'd0, e.nxt});
            checkOutput("invalid_column", e.tag, {15'd0, invalid_column}, {15'd0, e.inv});
            checkOutput("column_decode", e.tag, {14'd0, column_decode}, {14'd0, e.dec});
        end
    end

    task automatic addVec(input bit isRst, input logic [1:0] st, input logic [3:0] col,
                          input logic [3:0] colAfter, input int hold, input logic [15:0] board,
                          input logic [15:0] owner, input logic nxt, input logic inv);
        vec_t v;
        v = '{isRst, st, col, colAfter, hold, board, owner, nxt, inv};
        vecs.push_back(v);
    endtask

    // Inputs change 1 time unit after the edge; expectations target the cycle whose
    // negedge sees the committed result.
    task automatic applyStimulus(input vec_t v, input int tag);
        @(posedge clk); #1;
        reset     = v.isReset;
        state     = v.st;
        in_column = v.col;
        for (int h = 0; h < v.hold; h++) begin
            expect_t e;
            @(posedge clk); #1;
            if (h == 0) in_column = v.colAfter;
            if (h == v.hold - 1) begin
                reset = 1'b0;
                state = 2'b00;
            end
            e = '{cycleCount, tag, v.board, v.owner, v.nxt, v.inv, decodeModel(in_column)};
            sb.push_back(e);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        state     = 2'b00;
        in_column = 4'b0000;
        repeat (2) @(posedge clk);

        addVec(1, 2'b00, 4'b0000, 4'b0000, 1, 16'h0000, 16'h0000, 0, 0);
        addVec(0, 2'b01, 4'b0001, 4'b0001, 1, 16'h0001, 16'h0000, 1, 0);
        addVec(0, 2'b10, 4'b0001, 4'b0001, 1, 16'h0011, 16'h0010, 0, 0);
        addVec(0, 2'b01, 4'b0001, 4'b0001, 1, 16'h0111, 16'h0010, 1, 0);
        addVec(0, 2'b10, 4'b0001, 4'b0001, 1, 16'h1111, 16'h1010, 0, 0);
        addVec(0, 2'b01, 4'b0001, 4'b0001, 1, 16'h1111, 16'h1010, 0, 1);
        addVec(0, 2'b01, 4'b0011, 4'b0011, 1, 16'h1111, 16'h1010, 0, 1);
        addVec(0, 2'b10, 4'b0010, 4'b0010, 1, 16'h1113, 16'h1012, 0, 0);
        addVec(0, 2'b01, 4'b0000, 4'b0000, 1, 16'h1113, 16'h1012, 0, 1);
        addVec(0, 2'b01, 4'b0100, 4'b0100, 5, 16'h1117, 16'h1012, 1, 0);
        addVec(0, 2'b11, 4'b1000, 4'b1000, 2, 16'h1117, 16'h1012, 1, 0);
        addVec(0, 2'b10, 4'b1000, 4'b0010, 3, 16'h111F, 16'h101A, 0, 0);
        addVec(1, 2'b00, 4'b0000, 4'b0000, 1, 16'h0000, 16'h0000, 0, 0);
        addVec(0, 2'b01, 4'b0100, 4'b0100, 1, 16'h0004, 16'h0000, 1, 0);
        addVec(0, 2'b10, 4'b0100, 4'b0100, 1, 16'h0044, 16'h0040, 0, 0);
        addVec(0, 2'b01, 4'b1000, 4'b1000, 1, 16'h004C, 16'h0040, 1, 0);
        addVec(1, 2'b10, 4'b0001, 4'b0001, 1, 16'h0000, 16'h0000, 0, 0);
        addVec(0, 2'b10, 4'b0010, 4'b0010, 1, 16'h0002, 16'h0002, 0, 0);

        foreach (vecs[i]) applyStimulus(vecs[i], i);

        for (int w = 0; w < 20 && sb.size() > 0; w++) @(posedge clk);
        if (sb.size() > 0) begin
            testsRun++;
            failCount++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end
endmodule
